// File: rtl/count_display.sv
// count_display: registers a 4-bit count and scans it as two
// decimal digits onto a time-multiplexed 7-segment display.
module count_display #(
  parameter int REFRESH_DIV   = 4,
  parameter int BLANK_LEADING = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] count,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       changed
);

  localparam int DW =
    (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    UNITS = 2'd1,
    TENS  = 2'd2
  } state_t;

  state_t        state;
  logic [DW-1:0] div;
  logic [3:0]    cnt_q;
  logic [3:0]    units_f;
  logic          tens_f;

  logic          tens_d;
  logic [3:0]    units_d;
  logic          blank;

  // 7-segment encoding, seg[0]=a .. seg[6]=g
  function automatic logic [6:0] enc(input logic [3:0] d);
    logic [6:0] s;
    s = 7'h00;
    case (d)
      4'd0: s = 7'h3F;
      4'd1: s = 7'h06;
      4'd2: s = 7'h5B;
      4'd3: s = 7'h4F;
      4'd4: s = 7'h66;
      4'd5: s = 7'h6D;
      4'd6: s = 7'h7D;
      4'd7: s = 7'h07;
      4'd8: s = 7'h7F;
      4'd9: s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  assign tens_d  = (cnt_q >= 4'd10);
  assign units_d = cnt_q - (tens_d ? 4'd10 : 4'd0);
  assign blank   = !tens_f && (BLANK_LEADING != 0);

  // input register and one-cycle change pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= 4'd0;
      changed <= 1'b0;
    end else begin
      cnt_q   <= count;
      changed <= (count != cnt_q);
    end
  end

  // scan FSM; the frame is latched only when UNITS is entered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= OFF;
      div     <= '0;
      units_f <= 4'd0;
      tens_f  <= 1'b0;
    end else begin
      case (state)
        OFF: begin
          if (en) begin
            state   <= UNITS;
            div     <= '0;
            units_f <= units_d;
            tens_f  <= tens_d;
          end
        end
        default: begin
          if (!en) begin
            state <= OFF;
            div   <= '0;
          end else if (div == DIV_LAST) begin
            div <= '0;
            if (state == UNITS) begin
              state <= TENS;
            end else begin
              state   <= UNITS;
              units_f <= units_d;
              tens_f  <= tens_d;
            end
          end else begin
            div <= div + 1'b1;
          end
        end
      endcase
    end
  end

  // output decode from registered state and frame only
  always_comb begin
    an  = 2'b00;
    seg = 7'h00;
    case (state)
      UNITS: begin
        an  = 2'b01;
        seg = enc(units_f);
      end
      TENS: begin
        if (!blank) begin
          an  = 2'b10;
          seg = enc({3'b000, tens_f});
        end
      end
      default: begin
        an  = 2'b00;
        seg = 7'h00;
      end
    endcase
  end

endmodule
